// File: rtl/coin_spin_animator.sv
// Coin sprite address/animation stage: box test, ROM address, spin frame select
// and the collect (rise-then-vanish) animation, all paced by a synchronised frame_clk.
module coin_spin_animator #(
    parameter int unsigned SPRITE_W       = 20,
    parameter int unsigned SPRITE_H       = 20,
    parameter int unsigned NUM_FRAMES     = 4,
    parameter int unsigned TICKS_PER_STEP = 8,
    parameter int unsigned COLLECT_TICKS  = 16,
    parameter int unsigned RISE_PX        = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] CoinX,
    input  logic [9:0] CoinY,
    input  logic       coin_active,
    input  logic       collect,
    output logic [8:0] read_address,
    output logic [1:0] frame_sel,
    output logic       coin_on,
    output logic       collecting,
    output logic       done
);

    localparam int unsigned COORD_W = 11;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned FRAME_W = 2;
    localparam int unsigned SPIN_W  = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int unsigned CTICK_W = (COLLECT_TICKS > 1) ? $clog2(COLLECT_TICKS) : 1;

    localparam logic signed [COORD_W-1:0] SPRITE_W_S = COORD_W'(SPRITE_W);
    localparam logic signed [COORD_W-1:0] SPRITE_H_S = COORD_W'(SPRITE_H);
    localparam logic [SPIN_W-1:0]         SPIN_LAST  = SPIN_W'(TICKS_PER_STEP - 1);
    localparam logic [CTICK_W-1:0]        CTICK_LAST = CTICK_W'(COLLECT_TICKS - 1);
    localparam logic [FRAME_W-1:0]        FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [COORD_W-1:0]        RISE_STEP  = COORD_W'(RISE_PX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPIN    = 2'd1,
        COLLECT = 2'd2
    } state_t;

    state_t               state;
    logic [SPIN_W-1:0]    spin_cnt;
    logic [CTICK_W-1:0]   ctick;
    logic [COORD_W-1:0]   rise;

    logic fclk_meta;
    logic fclk_sync;
    logic fclk_prev;
    logic tick;

    // frame_clk crosses in through two flops; tick is a registered one-cycle rising-edge pulse
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fclk_meta <= 1'b0;
            fclk_sync <= 1'b0;
            fclk_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            fclk_meta <= frame_clk;
            fclk_sync <= fclk_meta;
            fclk_prev <= fclk_sync;
            tick      <= fclk_sync & ~fclk_prev;
        end
    end

    logic signed [COORD_W-1:0] top_c;
    logic signed [COORD_W-1:0] dx_c;
    logic signed [COORD_W-1:0] dy_c;
    logic                      inbox_c;
    logic [ADDR_W-1:0]         addr_c;
    logic [FRAME_W-1:0]        next_frame_c;

    // Box test in signed 11-bit space so a coin risen above row 0 clips instead of wrapping
    always_comb begin
        top_c   = $signed({1'b0, CoinY} - rise);
        dx_c    = $signed({1'b0, DrawX} - {1'b0, CoinX});
        dy_c    = $signed({1'b0, DrawY}) - top_c;
        inbox_c = !dx_c[COORD_W-1] && (dx_c < SPRITE_W_S) &&
                  !dy_c[COORD_W-1] && (dy_c < SPRITE_H_S) &&
                  !top_c[COORD_W-1];
        addr_c  = '0;
        if (inbox_c) begin
            addr_c = ADDR_W'($unsigned(dy_c)) * ADDR_W'(SPRITE_W) + ADDR_W'($unsigned(dx_c));
        end
        next_frame_c = (frame_sel == FRAME_LAST) ? '0 : frame_sel + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            spin_cnt     <= '0;
            ctick        <= '0;
            rise         <= '0;
            frame_sel    <= '0;
            collecting   <= 1'b0;
            done         <= 1'b0;
            coin_on      <= 1'b0;
            read_address <= '0;
        end else begin
            done         <= 1'b0;
            coin_on      <= inbox_c && (state != IDLE);
            read_address <= addr_c;

            case (state)
                IDLE: begin
                    if (coin_active) begin
                        state     <= SPIN;
                        spin_cnt  <= '0;
                        frame_sel <= '0;
                    end
                end

                SPIN: begin
                    if (!coin_active) begin
                        state <= IDLE;
                    end else if (collect) begin
                        state      <= COLLECT;
                        collecting <= 1'b1;
                        rise       <= '0;
                        ctick      <= '0;
                    end else if (tick) begin
                        if (spin_cnt == SPIN_LAST) begin
                            spin_cnt  <= '0;
                            frame_sel <= next_frame_c;
                        end else begin
                            spin_cnt <= spin_cnt + 1'b1;
                        end
                    end
                end

                // coin_active and collect are deliberately ignored until the animation ends
                COLLECT: begin
                    if (tick) begin
                        frame_sel <= next_frame_c;
                        rise      <= rise + RISE_STEP;
                        ctick     <= ctick + 1'b1;
                        if (ctick == CTICK_LAST) begin
                            state      <= IDLE;
                            collecting <= 1'b0;
                            done       <= 1'b1;
                            ctick      <= '0;
                            rise       <= '0;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    collecting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_spin_animator.sv
// Directed bench for coin_spin_animator: reset, addressing, spin cadence,
// collect animation, clipping and reset mid-collect.
module tb_coin_spin_animator;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] CoinX;
    logic [9:0] CoinY;
    logic       coin_active;
    logic       collect;
    logic [8:0] read_address;
    logic [1:0] frame_sel;
    logic       coin_on;
    logic       collecting;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int done_base;

    coin_spin_animator dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .CoinX        (CoinX),
        .CoinY        (CoinY),
        .coin_active  (coin_active),
        .collect      (collect),
        .read_address (read_address),
        .frame_sel    (frame_sel),
        .coin_on      (coin_on),
        .collecting   (collecting),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    // done is a single-cycle pulse, so one count per pulse; a stuck done over-counts
    always @(negedge Clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic pulse_tick();
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic set_pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
    endtask

    task automatic pulse_collect();
        collect = 1'b1;
        @(negedge Clk);
        collect = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        Reset_n     = 1'b0;
        frame_clk   = 1'b0;
        DrawX       = 10'd100;
        DrawY       = 10'd200;
        CoinX       = 10'd100;
        CoinY       = 10'd200;
        coin_active = 1'b1;
        collect     = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            frame_clk = ~frame_clk;
        end
        check("rst_frame_sel", 32'(frame_sel), 32'd0);
        check("rst_coin_on", 32'(coin_on), 32'd0);
        check("rst_collecting", 32'(collecting), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(read_address), 32'd0);

        coin_active = 1'b0;
        Reset_n     = 1'b1;
        repeat (3) @(negedge Clk);
        check("idle_coin_on", 32'(coin_on), 32'd0);
        check("idle_frame_sel", 32'(frame_sel), 32'd0);

        pulse_collect();
        @(negedge Clk);
        check("idle_collect_ignored", 32'(collecting), 32'd0);
        check("idle_collect_coin_on", 32'(coin_on), 32'd0);

        coin_active = 1'b1;
        repeat (2) @(negedge Clk);
        check("spin_origin_on", 32'(coin_on), 32'd1);
        check("spin_origin_addr", 32'(read_address), 32'd0);

        set_pix(119, 219);
        check("addr_max", 32'(read_address), 32'd399);
        check("addr_max_on", 32'(coin_on), 32'd1);
        set_pix(120, 219);
        check("right_edge_off", 32'(coin_on), 32'd0);
        check("right_edge_addr", 32'(read_address), 32'd0);
        set_pix(105, 203);
        check("addr_mid", 32'(read_address), 32'd65);
        set_pix(99, 200);
        check("left_edge_off", 32'(coin_on), 32'd0);
        set_pix(100, 220);
        check("bottom_edge_off", 32'(coin_on), 32'd0);
        set_pix(100, 200);
        check("origin_addr", 32'(read_address), 32'd0);
        check("origin_on", 32'(coin_on), 32'd1);

        repeat (7) pulse_tick();
        check("spin_7_ticks", 32'(frame_sel), 32'd0);
        pulse_tick();
        check("spin_8_ticks", 32'(frame_sel), 32'd1);
        repeat (8) pulse_tick();
        check("spin_16_ticks", 32'(frame_sel), 32'd2);
        repeat (8) pulse_tick();
        check("spin_24_ticks", 32'(frame_sel), 32'd3);
        repeat (8) pulse_tick();
        check("spin_32_ticks", 32'(frame_sel), 32'd0);
        check("spin_collecting", 32'(collecting), 32'd0);
        check("spin_no_done", 32'(done_cnt), 32'd0);

        pulse_collect();
        check("collect_entered", 32'(collecting), 32'd1);
        repeat (5) pulse_tick();
        check("collect_5_frame", 32'(frame_sel), 32'd1);
        set_pix(100, 190);
        check("risen_top_on", 32'(coin_on), 32'd1);
        check("risen_top_addr", 32'(read_address), 32'd0);
        set_pix(100, 189);
        check("above_risen_off", 32'(coin_on), 32'd0);
        set_pix(119, 209);
        check("risen_max_addr", 32'(read_address), 32'd399);

        coin_active = 1'b0;
        repeat (10) pulse_tick();
        check("collect_15_still", 32'(collecting), 32'd1);
        check("collect_15_frame", 32'(frame_sel), 32'd3);
        check("collect_15_no_done", 32'(done_cnt), 32'd0);
        set_pix(100, 170);
        check("collect_15_top_on", 32'(coin_on), 32'd1);
        set_pix(100, 200);
        pulse_tick();
        check("collect_done_once", 32'(done_cnt), 32'd1);
        check("collect_ended", 32'(collecting), 32'd0);
        check("collect_ended_off", 32'(coin_on), 32'd0);

        CoinY       = 10'd10;
        coin_active = 1'b1;
        repeat (2) @(negedge Clk);
        pulse_collect();
        check("clip_collecting", 32'(collecting), 32'd1);
        repeat (5) pulse_tick();
        set_pix(100, 0);
        check("top_zero_on", 32'(coin_on), 32'd1);
        set_pix(100, 19);
        check("top_zero_addr", 32'(read_address), 32'd380);
        pulse_tick();
        set_pix(100, 0);
        check("clip_row0", 32'(coin_on), 32'd0);
        set_pix(100, 8);
        check("clip_row8", 32'(coin_on), 32'd0);
        set_pix(119, 17);
        check("clip_corner", 32'(coin_on), 32'd0);
        check("clip_addr", 32'(read_address), 32'd0);

        pulse_tick();
        done_base = done_cnt;
        Reset_n   = 1'b0;
        @(negedge Clk);
        check("midrst_collecting", 32'(collecting), 32'd0);
        check("midrst_coin_on", 32'(coin_on), 32'd0);
        check("midrst_frame_sel", 32'(frame_sel), 32'd0);
        check("midrst_addr", 32'(read_address), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        CoinY = 10'd200;
        DrawX = 10'd100;
        DrawY = 10'd200;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        pulse_collect();
        check("restart_collecting", 32'(collecting), 32'd1);
        check("restart_rise0_on", 32'(coin_on), 32'd1);
        set_pix(100, 199);
        check("restart_rise0_above", 32'(coin_on), 32'd0);
        repeat (20) @(negedge Clk);
        check("midrst_no_done", 32'(done_cnt - done_base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
